// File: rtl/ctrl_io_config_frame_buffer.sv
// ctrl_io_config_frame_buffer
// ---------------------------------------------------------------------------
// Double-buffered configuration store for a control/IO tile. Frame words
// arriving on the column frame bus are captured into a shadow store on the
// rising edge of their per-frame strobe. A commit pulse then copies the whole
// shadow store into the active configuration in one cycle. The shadow can be
// read back one frame at a time. Strobe edges on more than one frame in the
// same cycle are rejected and flagged.
//
// Ports
//   CLK           clock; all state changes on the rising edge
//   reset         synchronous, active-high
//   FrameData     frame word; config bits live in the top UsedBitsPerFrame bits
//   FrameStrobe   per-frame write strobes (level, edge-detected here)
//   commit        copy shadow -> active this cycle
//   ConfigBits    active configuration
//   ConfigBits_N  bitwise complement of ConfigBits
//   shadow_dirty  shadow written since the last commit
//   rd_en         readback request
//   rd_frame      frame index to read back
//   rd_valid      rd_data valid (one cycle after rd_en)
//   rd_data       shadow frame contents, unused bit positions read as 0
//   strobe_err    sticky flag: multi-hot strobe edge seen since reset
module ctrl_io_config_frame_buffer #(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameBitsPerRow  = 32,
    parameter int NoConfigBits     = 23,
    parameter int UsedBitsPerFrame = 23,
    localparam int FW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       commit,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    output logic                       shadow_dirty,
    input  logic                       rd_en,
    input  logic [FW-1:0]              rd_frame,
    output logic                       rd_valid,
    output logic [FrameBitsPerRow-1:0] rd_data,
    output logic                       strobe_err
);

    localparam int NumFrames = (NoConfigBits + UsedBitsPerFrame - 1) / UsedBitsPerFrame;
    localparam int Lsb       = FrameBitsPerRow - UsedBitsPerFrame;
    // Readback table is padded to the full rd_frame range; padding rows are 0.
    localparam int RdDepth   = 1 << FW;

    if (NumFrames > MaxFramesPerCol || UsedBitsPerFrame < 1 ||
        UsedBitsPerFrame > FrameBitsPerRow) begin : g_bad_params
        $error("ctrl_io_config_frame_buffer: inconsistent frame geometry");
    end

    logic [MaxFramesPerCol-1:0]                    strb_q;
    logic [MaxFramesPerCol-1:0]                    rise;
    logic                                          multi_hot;
    logic                                          single_hot;
    logic [NumFrames-1:0]                          frame_we;
    logic                                          wr_any;
    logic [NoConfigBits-1:0]                       shadow;
    logic [NoConfigBits-1:0]                       shadow_nxt;
    logic [NoConfigBits-1:0]                       active;
    logic [RdDepth-1:0][FrameBitsPerRow-1:0]       frame_word;
    logic                                          unused_frame_bits;

    // Bits below Lsb carry no configuration.
    assign unused_frame_bits = ^FrameData;

    // Edge detect. strb_q resets to all ones so a strobe that is already
    // high when reset drops is not mistaken for a new edge.
    assign rise       = FrameStrobe & ~strb_q;
    // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
    assign multi_hot  = |(rise & (rise - MaxFramesPerCol'(1)));
    assign single_hot = (rise != '0) && !multi_hot;

    // Edges on frames >= NumFrames never reach a write enable.
    for (genvar f = 0; f < NumFrames; f++) begin : g_we
        assign frame_we[f] = single_hot & rise[f];
    end
    assign wr_any = |frame_we;

    // Config bit k lives in frame k/U at word bit Lsb + k%U.
    for (genvar k = 0; k < NoConfigBits; k++) begin : g_bit
        localparam int F = k / UsedBitsPerFrame;
        localparam int B = Lsb + (k % UsedBitsPerFrame);
        assign shadow_nxt[k] = frame_we[F] ? FrameData[B] : shadow[k];
    end

    // Inverse mapping for readback: every word bit is either a shadow bit or 0.
    for (genvar f = 0; f < RdDepth; f++) begin : g_rd_f
        for (genvar b = 0; b < FrameBitsPerRow; b++) begin : g_rd_b
            localparam int K = f * UsedBitsPerFrame + b - Lsb;
            if (f < NumFrames && b >= Lsb && K < NoConfigBits) begin : g_map
                assign frame_word[f][b] = shadow[K];
            end else begin : g_zero
                assign frame_word[f][b] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            strb_q       <= '1;
            shadow       <= '0;
            active       <= '0;
            shadow_dirty <= 1'b0;
            strobe_err   <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            strb_q <= FrameStrobe;
            shadow <= shadow_nxt;
            // Non-blocking read of shadow: commit takes the pre-write contents.
            if (commit) active <= shadow;
            // A write in the commit cycle leaves the shadow ahead of active.
            if (wr_any)      shadow_dirty <= 1'b1;
            else if (commit) shadow_dirty <= 1'b0;
            if (multi_hot) strobe_err <= 1'b1;
            rd_valid <= rd_en;
            rd_data  <= rd_en ? frame_word[rd_frame] : '0;
        end
    end

    assign ConfigBits   = active;
    assign ConfigBits_N = ~active;

endmodule

// File: tb/tb_ctrl_io_config_frame_buffer.sv
// Bench for ctrl_io_config_frame_buffer. Two instances share one stimulus
// stream: dut_a with default geometry (23 bits, one frame) and dut_b with
// 40 config bits in 16-bit frames (three frames). A frame-level model tracks
// both and is compared every cycle; directed steps add literal checks.
module tb_ctrl_io_config_frame_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fd;
    logic [19:0] fs;
    logic        commit;
    logic        rd_en;
    logic [4:0]  rd_frame;

    logic [22:0] cb_a, cbn_a;
    logic [39:0] cb_b, cbn_b;
    logic        dirty_a, dirty_b, rdv_a, rdv_b, err_a, err_b;
    logic [31:0] rdd_a, rdd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_io_config_frame_buffer dut_a (
        .CLK(clk), .reset(reset), .FrameData(fd), .FrameStrobe(fs), .commit(commit),
        .ConfigBits(cb_a), .ConfigBits_N(cbn_a), .shadow_dirty(dirty_a),
        .rd_en(rd_en), .rd_frame(rd_frame), .rd_valid(rdv_a), .rd_data(rdd_a),
        .strobe_err(err_a)
    );

    ctrl_io_config_frame_buffer #(.NoConfigBits(40), .UsedBitsPerFrame(16)) dut_b (
        .CLK(clk), .reset(reset), .FrameData(fd), .FrameStrobe(fs), .commit(commit),
        .ConfigBits(cb_b), .ConfigBits_N(cbn_b), .shadow_dirty(dirty_b),
        .rd_en(rd_en), .rd_frame(rd_frame), .rd_valid(rdv_b), .rd_data(rdd_b),
        .strobe_err(err_b)
    );

    // ---------------- model ----------------
    function automatic int ncb(int c); return (c == 0) ? 23 : 40; endfunction
    function automatic int ub(int c);  return (c == 0) ? 23 : 16; endfunction
    function automatic int nf(int c);  return (ncb(c) + ub(c) - 1) / ub(c); endfunction

    // Replace frame f of the configuration vector with the top ub bits of d.
    function automatic logic [63:0] wr_frame(int c, logic [63:0] sh, int f, logic [31:0] d);
        logic [63:0] m, v;
        m = (((64'd1 << ub(c)) - 64'd1) << (f * ub(c))) & ((64'd1 << ncb(c)) - 64'd1);
        v = ({32'd0, d} >> (32 - ub(c))) << (f * ub(c));
        return (sh & ~m) | (v & m);
    endfunction

    function automatic logic [31:0] rd_word(int c, logic [63:0] sh, int f);
        logic [63:0] w;
        if (f >= nf(c)) return 32'd0;
        w = ((sh >> (f * ub(c))) & ((64'd1 << ub(c)) - 64'd1)) << (32 - ub(c));
        return w[31:0];
    endfunction

    logic [63:0] m_sh [2];
    logic [63:0] m_act [2];
    logic        m_dirty [2];
    logic        m_err;
    logic        m_rdv;
    logic [31:0] m_rdd [2];
    logic [19:0] m_sq;

    task automatic model_step();
        logic [19:0] rise;
        logic [63:0] old;
        int n, idx;
        bit wr;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_sh[c] = '0; m_act[c] = '0; m_dirty[c] = 1'b0; m_rdd[c] = '0;
            end
            m_err = 1'b0; m_rdv = 1'b0; m_sq = '1;
        end else begin
            rise = fs & ~m_sq;
            m_sq = fs;
            n = $countones(rise);
            idx = 0;
            for (int i = 0; i < 20; i++) if (rise[i]) idx = i;
            if (n > 1) m_err = 1'b1;
            for (int c = 0; c < 2; c++) begin
                old = m_sh[c];
                wr = (n == 1) && (idx < nf(c));
                if (wr) m_sh[c] = wr_frame(c, m_sh[c], idx, fd);
                if (commit) m_act[c] = old;
                if (wr) m_dirty[c] = 1'b1;
                else if (commit) m_dirty[c] = 1'b0;
                m_rdd[c] = rd_en ? rd_word(c, old, int'(rd_frame)) : 32'd0;
            end
            m_rdv = rd_en;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, 1 time unit after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        chk("m_cb_a",    64'(cb_a),    {41'd0, m_act[0][22:0]});
        chk("m_cbn_a",   64'(cbn_a),   {41'd0, ~m_act[0][22:0]});
        chk("m_cb_b",    64'(cb_b),    {24'd0, m_act[1][39:0]});
        chk("m_cbn_b",   64'(cbn_b),   {24'd0, ~m_act[1][39:0]});
        chk("m_dirty_a", 64'(dirty_a), 64'(m_dirty[0]));
        chk("m_dirty_b", 64'(dirty_b), 64'(m_dirty[1]));
        chk("m_err_a",   64'(err_a),   64'(m_err));
        chk("m_err_b",   64'(err_b),   64'(m_err));
        chk("m_rdv_a",   64'(rdv_a),   64'(m_rdv));
        chk("m_rdv_b",   64'(rdv_b),   64'(m_rdv));
        if (m_rdv) begin
            chk("m_rdd_a", 64'(rdd_a), 64'(m_rdd[0]));
            chk("m_rdd_b", 64'(rdd_b), 64'(m_rdd[1]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; fd = '0; fs = '0; commit = 1'b0; rd_en = 1'b0; rd_frame = '0;
        tick(); tick();
        chk("rst_cb_a",   64'(cb_a),  64'h0);
        chk("rst_cbn_a",  64'(cbn_a), 64'h7FFFFF);
        chk("rst_cbn_b",  64'(cbn_b), 64'hFF_FFFF_FFFF);
        chk("rst_dirty",  64'(dirty_a), 64'h0);
        chk("rst_err",    64'(err_a), 64'h0);
        chk("rst_rdv",    64'(rdv_a), 64'h0);
        chk("rst_rdd",    64'(rdd_a), 64'h0);
        reset = 1'b0;
        tick();

        // Held strobe writes once; later data changes are ignored.
        fd = 32'hFFFFFE00; fs = 20'h1; tick();
        chk("t1_dirty", 64'(dirty_a), 64'h1);
        chk("t1_cb_pre", 64'(cb_a), 64'h0);
        fd = 32'h0; tick(); tick();
        fs = '0; commit = 1'b1; tick(); commit = 1'b0;
        chk("t1_cb",    64'(cb_a),  64'h7FFFFF);
        chk("t1_cbn",   64'(cbn_a), 64'h0);
        chk("t1_clean", 64'(dirty_a), 64'h0);

        // Readback, out-of-range frame, and read racing a write.
        fd = 32'hA5A5A5FF; fs = 20'h1; tick();
        fs = '0; rd_en = 1'b1; rd_frame = 5'd0; tick();
        chk("t2_rdv",   64'(rdv_a), 64'h1);
        chk("t2_rdd_a", 64'(rdd_a), 64'hA5A5A400);
        chk("t2_rdd_b", 64'(rdd_b), 64'hA5A50000);
        rd_frame = 5'd5; tick();
        chk("t2_rdd_oob", 64'(rdd_a), 64'h0);
        chk("t2_rdv_oob", 64'(rdv_a), 64'h1);
        rd_en = 1'b0; tick();
        chk("t2_rdv_idle", 64'(rdv_a), 64'h0);
        fd = 32'h12345600; fs = 20'h1; rd_en = 1'b1; rd_frame = 5'd0; tick();
        chk("t2_rd_prewrite", 64'(rdd_a), 64'hA5A5A400);
        fs = '0; rd_en = 1'b0; tick();

        // Multi-hot edge is rejected and flagged; later single edge still writes.
        fd = 32'hDEADBEEF; fs = 20'h3; tick();
        chk("t3_err_a", 64'(err_a), 64'h1);
        chk("t3_err_b", 64'(err_b), 64'h1);
        fs = '0; rd_en = 1'b1; rd_frame = 5'd0; tick();
        chk("t3_unchanged", 64'(rdd_a), 64'h12345600);
        rd_en = 1'b0; fs = 20'h1; tick();
        fs = '0; rd_en = 1'b1; tick();
        chk("t3_write_after", 64'(rdd_a), 64'hDEADBE00);
        chk("t3_err_sticky",  64'(err_a), 64'h1);
        rd_en = 1'b0;

        // Three-frame geometry on dut_b; frames 1,2 are out of range for dut_a.
        fd = 32'h12340000; fs = 20'h1; tick();
        fd = 32'hABCD0000; fs = 20'h2; tick();
        fd = 32'hFFFF0000; fs = 20'h4; tick();
        fs = '0; commit = 1'b1; tick(); commit = 1'b0;
        chk("t4_cb_b", 64'(cb_b), 64'hFF_ABCD_1234);
        chk("t4_cb_a", 64'(cb_a), 64'h091A00);
        rd_en = 1'b1; rd_frame = 5'd2; tick(); rd_en = 1'b0;
        chk("t4_rd_f2_b", 64'(rdd_b), 64'h00FF0000);
        chk("t4_rd_f2_a", 64'(rdd_a), 64'h0);

        // Commit coinciding with a write.
        fd = 32'h77770000; fs = 20'h1; tick();
        fs = '0; tick();
        fd = 32'h55550000; fs = 20'h1; commit = 1'b1; tick();
        chk("t5_cb_old",    64'(cb_b), 64'hFF_ABCD_7777);
        chk("t5_dirty_hold", 64'(dirty_b), 64'h1);
        fs = '0; tick(); commit = 1'b0;
        chk("t5_cb_new",   64'(cb_b), 64'hFF_ABCD_5555);
        chk("t5_dirty_clr", 64'(dirty_b), 64'h0);

        // Reset with the strobe held high.
        fd = 32'hFFFFFE00; fs = 20'h1; tick();
        commit = 1'b1; tick(); commit = 1'b0;
        chk("t6_cb_pre", 64'(cb_a), 64'h7FFFFF);
        reset = 1'b1; tick();
        chk("t6_rst_cb",  64'(cb_a),  64'h0);
        chk("t6_rst_cbn", 64'(cbn_a), 64'h7FFFFF);
        chk("t6_rst_err", 64'(err_a), 64'h0);
        reset = 1'b0; tick(); tick();
        commit = 1'b1; tick(); commit = 1'b0;
        chk("t6_no_write", 64'(cb_a), 64'h0);
        chk("t6_clean",    64'(dirty_a), 64'h0);
        fs = '0; tick();
        fs = 20'h1; tick();
        chk("t6_dirty", 64'(dirty_a), 64'h1);
        commit = 1'b1; tick(); commit = 1'b0;
        chk("t6_cb", 64'(cb_a), 64'h7FFFFF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_io_config_frame_buffer.md
Name: ctrl_io_config_frame_buffer

Overview:
Clocked, parametrised configuration memory for a control/IO tile. It captures frame words from the column frame bus into a shadow store on rising edges of per-frame strobes. A commit pulse then transfers the shadow store to the active ConfigBits atomically. Shadow contents can be read back one frame at a time, and multi-hot strobe errors are flagged.

Parameters:
MaxFramesPerCol, 20, width of FrameStrobe; upper bound on frames used
FrameBitsPerRow, 32, width of FrameData and rd_data
NoConfigBits, 23, number of configuration bits delivered
UsedBitsPerFrame, 23, config bits carried per frame, in the top bits of FrameData; 1..FrameBitsPerRow
(derived) NumFrames = ceil(NoConfigBits/UsedBitsPerFrame); elaboration error if > MaxFramesPerCol
(derived) Lsb = FrameBitsPerRow - UsedBitsPerFrame; FW = max(1, clog2(MaxFramesPerCol))

Ports:
CLK  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
FrameData  in  FrameBitsPerRow  frame word
FrameStrobe  in  MaxFramesPerCol  per-frame write strobes (level; edge-detected internally)
commit  in  1  copy shadow to active on this cycle
ConfigBits  out  NoConfigBits  active configuration
ConfigBits_N  out  NoConfigBits  bitwise complement of ConfigBits
shadow_dirty  out  1  shadow differs in write history from active (written since last commit)
rd_en  in  1  readback request
rd_frame  in  FW  frame index to read
rd_valid  out  1  rd_data valid
rd_data  out  FrameBitsPerRow  shadow frame contents, unused bits 0
strobe_err  out  1  sticky: multi-hot strobe edge seen

Behaviour:
- Bit mapping: shadow/config bit k belongs to frame f = k / UsedBitsPerFrame, at FrameData bit Lsb + (k mod UsedBitsPerFrame). Frame-word bits below Lsb, and bits mapping to k >= NoConfigBits, are ignored on write and read as 0.
- With the defaults: ConfigBits[22] = FrameData[31] through ConfigBits[0] = FrameData[9], all in frame 0.
- Edge detect: register strb_q <= FrameStrobe. rise = FrameStrobe & ~strb_q.
- Write when rise is one-hot at index f < NumFrames: the mapped shadow bits take FrameData sampled in that same cycle. Shadow is visible in the next cycle. shadow_dirty is set.
- rise one-hot at f >= NumFrames: no write, no error.
- rise with more than one bit set: no write at all; strobe_err is set. strobe_err clears only on reset.
- Strobe held high over multiple cycles: exactly one write.
- commit: active <= shadow as it was before any write in the same cycle. ConfigBits changes in the cycle after commit. shadow_dirty clears unless a write occurs in the same cycle, in which case it stays 1.
- commit with no prior write: active is reloaded with identical values; no visible change.
- Readback: rd_en in cycle N gives rd_valid = 1 and rd_data = shadow frame rd_frame in cycle N+1. Latency is 1, with no backpressure, and one request per cycle is allowed.
- If a write to the same frame occurs in cycle N, rd_data returns the pre-write value.
- rd_frame >= NumFrames: rd_valid = 1, rd_data = 0.
- rd_valid = 0 in any cycle after a cycle without rd_en.
- Reset (applies at any point, including mid-write or mid-commit), all effective from the next edge:
  - shadow and active = 0; ConfigBits = 0; ConfigBits_N = all 1s
  - shadow_dirty = 0, strobe_err = 0, rd_valid = 0, rd_data = 0
  - strb_q = all 1s, so a strobe already high when reset deasserts does not write
- ConfigBits_N is always the exact complement of ConfigBits and comes from the same register.

Test Plan:
- Defaults. Reset, then FrameData = 0xFFFFFE00 and FrameStrobe = 0x1 for 3 cycles, then commit -> shadow_dirty = 1 after the write. ConfigBits = 0 until commit, then 0x7FFFFF with ConfigBits_N = 0; exactly one write occurs.
- Defaults. Write FrameData = 0xA5A5A5FF to frame 0, then rd_en with rd_frame = 0 -> next cycle rd_valid = 1, rd_data = 0xA5A5A400 (bits 8:0 zero). rd_frame = 5 -> rd_data = 0.
- FrameStrobe 0x0 -> 0x3 -> strobe_err = 1 and shadow unchanged. A following single strobe still writes; strobe_err stays 1 until reset.
- NoConfigBits = 40, UsedBitsPerFrame = 16. Write frame 0 with FrameData = 0x1234_0000, frame 1 with 0xABCD_0000, frame 2 with 0xFFFF_0000, then commit -> ConfigBits = 0xFF_ABCD_1234. Frame 2 readback = 0x00FF_0000.
- Commit and a frame-0 write in the same cycle -> active takes the old shadow, shadow takes the new word, shadow_dirty stays 1. A second commit makes the new value active.
- Reset asserted while FrameStrobe[0] is held high, with active = 0x7FFFFF -> ConfigBits = 0 and no write after reset deasserts. Toggling the strobe low then high writes normally.
